// File: rtl/amo_arbiter.sv
// amo_arbiter: per-agent LR/SC reservation slots with store snooping and a
// lifetime counter, plus a round-robin arbitrated read-modify-write ALU whose
// result appears one cycle after the grant.

package riscv_types;
    typedef enum logic [3:0] {
        AMO_LR   = 4'd0,
        AMO_SC   = 4'd1,
        AMO_SWAP = 4'd2,
        AMO_ADD  = 4'd3,
        AMO_XOR  = 4'd4,
        AMO_AND  = 4'd5,
        AMO_OR   = 4'd6,
        AMO_MIN  = 4'd7,
        AMO_MAX  = 4'd8,
        AMO_MINU = 4'd9,
        AMO_MAXU = 4'd10
    } amo_t;
endpackage

// Handshake: rmw_req[i] is held by agent i until it sees rmw_gnt[i] in the same
// cycle; a cycle with rmw_req[i] & rmw_gnt[i] is the accepted transfer and its
// operands are captured at that clock edge. rd_valid[i] then strobes for exactly
// one cycle with the result on rd; there is no backpressure on the result.
module amo_arbiter
    import riscv_types::*;
#(
    parameter int NUM_UNITS         = 4,
    parameter int XLEN              = 32,
    parameter int RESERVATION_WORDS = 4,
    parameter int LR_TIMEOUT        = 64
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_UNITS-1:0]            set_reservation,
    input  logic [NUM_UNITS-1:0]            clear_reservation,
    input  logic [NUM_UNITS-1:0][XLEN-1:0]  reservation_addr,
    output logic [NUM_UNITS-1:0]            reservation_valid,
    input  logic [NUM_UNITS-1:0]            store_valid,
    input  logic [NUM_UNITS-1:0][XLEN-1:0]  store_addr,
    input  logic [NUM_UNITS-1:0]            rmw_req,
    input  amo_t                            rmw_op [NUM_UNITS],
    input  logic [NUM_UNITS-1:0][XLEN-1:0]  rmw_rs1,
    input  logic [NUM_UNITS-1:0][XLEN-1:0]  rmw_rs2,
    output logic [NUM_UNITS-1:0]            rmw_gnt,
    output logic [NUM_UNITS-1:0]            rd_valid,
    output logic [XLEN-1:0]                 rd
);
    localparam int GW = XLEN - 2 - $clog2(RESERVATION_WORDS);
    localparam int CW = (LR_TIMEOUT > 0) ? $clog2(LR_TIMEOUT + 1) : 1;
    localparam int PW = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(LR_TIMEOUT);

    logic [NUM_UNITS-1:0] valid_q, valid_d;
    logic [GW-1:0]        tag_q [NUM_UNITS];
    logic [GW-1:0]        tag_d [NUM_UNITS];
    logic [CW-1:0]        cnt_q [NUM_UNITS];
    logic [CW-1:0]        cnt_d [NUM_UNITS];
    logic [GW-1:0]        res_tag [NUM_UNITS];
    logic [GW-1:0]        st_tag [NUM_UNITS];
    logic [NUM_UNITS-1:0] snoop_hit;
    logic [PW-1:0]        ptr_q, ptr_d;
    logic [NUM_UNITS-1:0] gnt_q, gnt_d;
    amo_t                 op_q, op_d;
    logic [XLEN-1:0]      rs1_q, rs1_d, rs2_q, rs2_d;
    logic                 unused_addr_bits;

    // Granule tags of the lookup and snooped store addresses; word offsets are dropped.
    always_comb begin
        unused_addr_bits = 1'b0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            res_tag[i] = reservation_addr[i][XLEN-1 -: GW];
            st_tag[i]  = store_addr[i][XLEN-1 -: GW];
            unused_addr_bits = unused_addr_bits ^ (^reservation_addr[i][XLEN-GW-1:0])
                                                ^ (^store_addr[i][XLEN-GW-1:0]);
        end
    end

    // A store from any other agent into a held granule kills that reservation.
    always_comb begin
        snoop_hit = '0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            for (int j = 0; j < NUM_UNITS; j++) begin
                if (j != i && store_valid[j] && st_tag[j] == tag_q[i]) begin
                    snoop_hit[i] = 1'b1;
                end
            end
        end
    end

    // Reservation slot update: set beats clear, snoop kill and expiry.
    always_comb begin
        for (int i = 0; i < NUM_UNITS; i++) begin
            valid_d[i] = valid_q[i];
            tag_d[i]   = tag_q[i];
            cnt_d[i]   = cnt_q[i];
            if (set_reservation[i]) begin
                valid_d[i] = 1'b1;
                tag_d[i]   = res_tag[i];
                cnt_d[i]   = CNT_INIT;
            end else begin
                if (LR_TIMEOUT > 0 && valid_q[i] && cnt_q[i] != '0) begin
                    cnt_d[i] = cnt_q[i] - CW'(1);
                end
                if (clear_reservation[i] || snoop_hit[i] ||
                    (LR_TIMEOUT > 0 && valid_q[i] && cnt_q[i] == CW'(1))) begin
                    valid_d[i] = 1'b0;
                end
            end
            reservation_valid[i] = valid_q[i] && (tag_q[i] == res_tag[i]);
        end
    end

    // Round-robin grant: search starts at ptr_q; pointer moves past the winner.
    always_comb begin
        rmw_gnt = '0;
        ptr_d   = ptr_q;
        for (int k = 0; k < NUM_UNITS; k++) begin
            for (int j = 0; j < NUM_UNITS; j++) begin
                if (rst && rmw_gnt == '0 && rmw_req[j] &&
                    j == (int'(ptr_q) + k) % NUM_UNITS) begin
                    rmw_gnt[j] = 1'b1;
                    ptr_d      = (j == NUM_UNITS - 1) ? '0 : PW'(j + 1);
                end
            end
        end
    end

    // Capture the winner's operation; operands hold when nothing is granted so rd holds.
    always_comb begin
        gnt_d = rmw_gnt;
        op_d  = op_q;
        rs1_d = rs1_q;
        rs2_d = rs2_q;
        for (int i = 0; i < NUM_UNITS; i++) begin
            if (rmw_gnt[i]) begin
                op_d  = rmw_op[i];
                rs1_d = rmw_rs1[i];
                rs2_d = rmw_rs2[i];
            end
        end
    end

    // Result from the registered operands; LR, SC and SWAP all return rs2.
    always_comb begin
        rd_valid = gnt_q;
        case (op_q)
            AMO_ADD:  rd = rs1_q + rs2_q;
            AMO_XOR:  rd = rs1_q ^ rs2_q;
            AMO_AND:  rd = rs1_q & rs2_q;
            AMO_OR:   rd = rs1_q | rs2_q;
            AMO_MIN:  rd = ($signed(rs1_q) < $signed(rs2_q)) ? rs1_q : rs2_q;
            AMO_MAX:  rd = ($signed(rs1_q) > $signed(rs2_q)) ? rs1_q : rs2_q;
            AMO_MINU: rd = (rs1_q < rs2_q) ? rs1_q : rs2_q;
            AMO_MAXU: rd = (rs1_q > rs2_q) ? rs1_q : rs2_q;
            default:  rd = rs2_q;
        endcase
    end

    // State registers; reset drops reservations and any in-flight result.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
            for (int i = 0; i < NUM_UNITS; i++) begin
                tag_q[i] <= '0;
                cnt_q[i] <= '0;
            end
            ptr_q <= '0;
            gnt_q <= '0;
            op_q  <= AMO_LR;
            rs1_q <= '0;
            rs2_q <= '0;
        end else begin
            valid_q <= valid_d;
            for (int i = 0; i < NUM_UNITS; i++) begin
                tag_q[i] <= tag_d[i];
                cnt_q[i] <= cnt_d[i];
            end
            ptr_q <= ptr_d;
            gnt_q <= gnt_d;
            op_q  <= op_d;
            rs1_q <= rs1_d;
            rs2_q <= rs2_d;
        end
    end
endmodule

// File: tb/tb_amo_arbiter.sv
// Bench for amo_arbiter: directed scenarios followed by random traffic, all
// compared each cycle against a cycle-count based reference model.
module tb_amo_arbiter;
    import riscv_types::*;

    localparam int N    = 4;
    localparam int XLEN = 32;
    localparam int RW   = 4;
    localparam int LRT  = 4;
    localparam int GRAN_BYTES = RW * 4;

    logic                  clk = 1'b0;
    logic                  rst = 1'b0;
    logic [N-1:0]          set_reservation, clear_reservation, store_valid, rmw_req;
    logic [N-1:0][XLEN-1:0] reservation_addr, store_addr, rmw_rs1, rmw_rs2;
    amo_t                  rmw_op [N];
    logic [N-1:0]          reservation_valid, rmw_gnt, rd_valid;
    logic [XLEN-1:0]       rd;

    int n_cmp = 0;
    int n_mis = 0;

    // Reference model state
    bit          m_live [N];
    int          m_set_cyc [N];
    int unsigned m_gran [N];
    int          m_prio;
    logic [N-1:0]    m_rdv;
    logic [XLEN-1:0] m_rd;
    int          cyc = 0;

    amo_arbiter #(
        .NUM_UNITS(N), .XLEN(XLEN), .RESERVATION_WORDS(RW), .LR_TIMEOUT(LRT)
    ) dut (
        .clk(clk), .rst(rst),
        .set_reservation(set_reservation), .clear_reservation(clear_reservation),
        .reservation_addr(reservation_addr), .reservation_valid(reservation_valid),
        .store_valid(store_valid), .store_addr(store_addr),
        .rmw_req(rmw_req), .rmw_op(rmw_op), .rmw_rs1(rmw_rs1), .rmw_rs2(rmw_rs2),
        .rmw_gnt(rmw_gnt), .rd_valid(rd_valid), .rd(rd)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int unsigned gran(input logic [XLEN-1:0] a);
        return a / GRAN_BYTES;
    endfunction

    function automatic logic [XLEN-1:0] alu(input amo_t op, input logic [XLEN-1:0] a,
                                            input logic [XLEN-1:0] b);
        int sa, sb;
        longint unsigned ua, ub;
        sa = a; sb = b; ua = a; ub = b;
        case (op)
            AMO_ADD:  return XLEN'(ua + ub);
            AMO_XOR:  return a ^ b;
            AMO_AND:  return a & b;
            AMO_OR:   return a | b;
            AMO_MIN:  return (sa <= sb) ? a : b;
            AMO_MAX:  return (sa >= sb) ? a : b;
            AMO_MINU: return (ua <= ub) ? a : b;
            AMO_MAXU: return (ua >= ub) ? a : b;
            default:  return b;
        endcase
    endfunction

    // Winning agent for the current inputs, -1 when none.
    function automatic int model_gnt();
        if (!rst) return -1;
        for (int k = 0; k < N; k++) begin
            if (rmw_req[(m_prio + k) % N]) return (m_prio + k) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_live[i] = 1'b0;
            m_set_cyc[i] = 0;
            m_gran[i] = 0;
        end
        m_prio = 0;
        m_rdv  = '0;
        m_rd   = '0;
    endtask

    task automatic model_update();
        int g;
        bit hit;
        if (!rst) begin
            model_reset();
            cyc++;
            return;
        end
        g = model_gnt();
        for (int i = 0; i < N; i++) begin
            hit = 1'b0;
            for (int j = 0; j < N; j++) begin
                if (j != i && store_valid[j] && gran(store_addr[j]) == m_gran[i]) hit = 1'b1;
            end
            if (set_reservation[i]) begin
                m_live[i] = 1'b1;
                m_set_cyc[i] = cyc;
                m_gran[i] = gran(reservation_addr[i]);
            end else if (clear_reservation[i] || hit) begin
                m_live[i] = 1'b0;
            end
        end
        if (g >= 0) begin
            m_rd  = alu(rmw_op[g], rmw_rs1[g], rmw_rs2[g]);
            m_rdv = '0;
            m_rdv[g] = 1'b1;
            m_prio = (g + 1) % N;
        end else begin
            m_rdv = '0;
        end
        cyc++;
    endtask

    task automatic check_all();
        int g;
        logic [N-1:0] eg, er;
        g = model_gnt();
        eg = '0;
        if (g >= 0) eg[g] = 1'b1;
        for (int i = 0; i < N; i++) begin
            er[i] = m_live[i] && (cyc - m_set_cyc[i] <= LRT) &&
                    (gran(reservation_addr[i]) == m_gran[i]);
        end
        check("gnt", 64'(rmw_gnt), 64'(eg));
        check("res_valid", 64'(reservation_valid), 64'(er));
        check("rd_valid", 64'(rd_valid), 64'(m_rdv));
        check("rd", 64'(rd), 64'(m_rd));
    endtask

    // One clock: check at the falling edge, advance the model at the rising edge.
    task automatic step();
        @(negedge clk);
        check_all();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle();
        set_reservation   = '0;
        clear_reservation = '0;
        store_valid       = '0;
        rmw_req           = '0;
        for (int i = 0; i < N; i++) begin
            reservation_addr[i] = '0;
            store_addr[i] = '0;
            rmw_rs1[i] = '0;
            rmw_rs2[i] = '0;
            rmw_op[i]  = AMO_LR;
        end
    endtask

    initial begin
        idle();
        model_reset();
        // Request pending across reset must not be granted while reset is low
        rmw_req = 4'b0101;
        rmw_op[0] = AMO_ADD;  rmw_rs1[0] = 32'd5; rmw_rs2[0] = 32'd7;
        rmw_op[2] = AMO_SWAP; rmw_rs1[2] = 32'd3; rmw_rs2[2] = 32'd9;
        step();
        step();
        check("reset_gnt", 64'(rmw_gnt), 64'd0);
        check("reset_rd_valid", 64'(rd_valid), 64'd0);
        check("reset_rd", 64'(rd), 64'd0);
        check("reset_res_valid", 64'(reservation_valid), 64'd0);

        // Two-cycle request burst out of reset
        rst = 1'b1;
        #2 check("rr_first_gnt", 64'(rmw_gnt), 64'h1);
        step();
        #2 check("rr_second_gnt", 64'(rmw_gnt), 64'h4);
        check("add_rd", 64'(rd), 64'd12);
        check("add_rd_valid", 64'(rd_valid), 64'h1);
        step();
        rmw_req = '0;
        #2 check("swap_rd", 64'(rd), 64'd9);
        check("swap_rd_valid", 64'(rd_valid), 64'h4);
        step();
        #2 check("idle_rd_valid", 64'(rd_valid), 64'h0);
        check("idle_rd_hold", 64'(rd), 64'd9);

        // Signed vs unsigned minimum
        rmw_req = 4'b0010;
        rmw_op[1] = AMO_MIN; rmw_rs1[1] = 32'hFFFF_FFFF; rmw_rs2[1] = 32'd1;
        step();
        rmw_op[1] = AMO_MINU;
        #2 check("min_signed", 64'(rd), 64'hFFFF_FFFF);
        step();
        rmw_req = '0;
        #2 check("min_unsigned", 64'(rd), 64'd1);
        step();

        // Snoop: foreign store to another granule keeps, same granule kills
        set_reservation[1] = 1'b1;
        reservation_addr[1] = 32'h1000;
        step();
        set_reservation = '0;
        store_valid[2] = 1'b1; store_addr[2] = 32'h1010;
        #2 check("snoop_set", 64'(reservation_valid[1]), 64'd1);
        step();
        store_addr[2] = 32'h100C;
        #2 check("snoop_other_granule", 64'(reservation_valid[1]), 64'd1);
        step();
        store_valid = '0;
        #2 check("snoop_same_granule", 64'(reservation_valid[1]), 64'd0);
        step();

        // Timeout: valid for exactly LRT cycles after the set
        set_reservation[0] = 1'b1;
        reservation_addr[0] = 32'h2000;
        step();
        set_reservation = '0;
        for (int k = 1; k <= LRT + 2; k++) begin
            #2 check($sformatf("timeout_k%0d", k), 64'(reservation_valid[0]), 64'(k <= LRT));
            step();
        end

        // Set wins over clear and over a foreign snoop
        set_reservation = 4'b1001;
        clear_reservation[3] = 1'b1;
        reservation_addr[3] = 32'h3000;
        reservation_addr[0] = 32'h4000;
        store_valid[1] = 1'b1; store_addr[1] = 32'h4008;
        step();
        idle();
        reservation_addr[3] = 32'h3000;
        reservation_addr[0] = 32'h4000;
        #2 check("set_beats_clear_snoop", 64'(reservation_valid), 64'h9);
        step();

        // Reset right after a grant discards the result
        rmw_req = 4'b0100;
        rmw_op[2] = AMO_ADD; rmw_rs1[2] = 32'd1; rmw_rs2[2] = 32'd2;
        step();
        rst = 1'b0;
        model_reset();
        rmw_req = '0;
        #2 check("reset_mid_rd_valid", 64'(rd_valid), 64'd0);
        check("reset_mid_rd", 64'(rd), 64'd0);
        step();
        rst = 1'b1;
        step();

        // Random traffic
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                set_reservation[i]   = ($urandom_range(0, 3) == 0);
                clear_reservation[i] = ($urandom_range(0, 7) == 0);
                store_valid[i]       = ($urandom_range(0, 2) == 0);
                reservation_addr[i]  = 32'h1000 + 32'($urandom_range(0, 15)) * 4;
                store_addr[i]        = 32'h1000 + 32'($urandom_range(0, 15)) * 4;
                rmw_op[i]  = amo_t'($urandom_range(0, 10));
                rmw_rs1[i] = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom;
                rmw_rs2[i] = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
            end
            rmw_req = 4'($urandom_range(0, 15));
            if (!rst) begin
                rst = 1'b1;
            end else if ($urandom_range(0, 99) == 0) begin
                rst = 1'b0;
                model_reset();
            end
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule

// File: doc/amo_arbiter.md
AMO_ARBITER -- requirements
Module: amo_arbiter

Interface
REQ-001 Parameters SHALL be: NUM_UNITS, default 4, number of agents; XLEN, default 32, data/address width; RESERVATION_WORDS, default 4, words per reservation granule (power of 2); LR_TIMEOUT, default 64, reservation lifetime in cycles (0 = never expires).
REQ-002 Derived: GW = XLEN-2-$clog2(RESERVATION_WORDS) is the granule tag width, taken as addr[XLEN-1 -: GW].
REQ-003 Ports, one per line:
 clk  in  1  sole clock, rising edge.
 rst  in  1  asynchronous, active-low reset.
 set_reservation  in  NUM_UNITS  per-agent LR: set own reservation.
 clear_reservation  in  NUM_UNITS  per-agent: clear own reservation (SC done or abort).
 reservation_addr  in  NUM_UNITS x XLEN  per-agent LR/SC address.
 reservation_valid  out  NUM_UNITS  own reservation held and its tag matches reservation_addr[i].
 store_valid  in  NUM_UNITS  per-agent committed store (snoop).
 store_addr  in  NUM_UNITS x XLEN  per-agent store address.
 rmw_req  in  NUM_UNITS  per-agent RMW request.
 rmw_op  in  NUM_UNITS x amo_t  per-agent operation (riscv_types amo_t).
 rmw_rs1  in  NUM_UNITS x XLEN  memory operand.
 rmw_rs2  in  NUM_UNITS x XLEN  register operand.
 rmw_gnt  out  NUM_UNITS  one-hot grant, same cycle as the accepted request.
 rd_valid  out  NUM_UNITS  one-hot result strobe.
 rd  out  XLEN  shared RMW result.

Function
REQ-004 Each agent SHALL own one reservation slot: valid bit, GW-bit tag, timeout counter of width $clog2(LR_TIMEOUT+1).
REQ-005 On set_reservation[i]: valid[i]<=1, tag[i]<=tag of reservation_addr[i], counter[i]<=LR_TIMEOUT.
REQ-006 On clear_reservation[i] without set_reservation[i]: valid[i]<=0; set wins when both are asserted.
REQ-007 store_valid[j] with a tag equal to tag[i], j!=i, SHALL clear valid[i] next cycle, unless set_reservation[i] is asserted in that cycle (set wins).
REQ-008 A store by agent i SHALL NOT clear its own reservation.
REQ-009 When LR_TIMEOUT>0 and valid[i]: counter decrements each cycle; a cycle with valid[i] and counter[i]==1 SHALL clear valid[i]; the counter SHALL NOT wrap below 0.
REQ-010 reservation_valid[i] = valid[i] & (tag[i] == tag of reservation_addr[i]), combinational.
REQ-011 rmw_gnt SHALL be a round-robin arbiter over rmw_req: the highest priority goes to the agent after the last granted one. rmw_gnt is combinational, at most one bit set, and zero when rmw_req is zero.
REQ-012 The granted op and operands SHALL be registered; rd and rd_valid (one-hot, the granted agent) SHALL appear exactly 1 cycle after the grant. Throughput is one RMW per cycle.
REQ-013 rd SHALL be computed on the registered operands: SWAP=rs2, ADD=rs1+rs2 modulo 2^XLEN, XOR/AND/OR bitwise, MIN/MAX signed, MINU/MAXU unsigned. LR/SC ops SHALL produce rd=rs2.
REQ-014 If no grant occurred in the previous cycle, rd_valid SHALL be 0 and rd SHALL hold its last value.
REQ-015 The round-robin pointer SHALL advance only on a grant. With NUM_UNITS=1, rmw_gnt = rmw_req.

Reset
REQ-016 While rst=0, asynchronously: all valid<=0, counters<=0, rd_valid<=0, rd<=0, RR pointer <= agent 0 having highest priority.
REQ-017 rmw_gnt SHALL be 0 during reset. A request pending when reset deasserts is arbitrated normally on the first clock after reset.
REQ-018 A reservation or in-flight RMW interrupted by reset SHALL be discarded without any output strobe.

Verification
REQ-019 RMW: rmw_req=4'b0101 for 2 cycles from reset, with ADD rs1=5, rs2=7 on agent 0 -> gnt 0001 then 0100; rd=12 with rd_valid=0001 one cycle after the first grant.
REQ-020 Snoop: agent 1 sets at 0x1000, agent 2 stores 0x100C (same granule) -> reservation_valid[1]=0 next cycle; a store by agent 2 to 0x1010 leaves it at 1.
REQ-021 Timeout: LR_TIMEOUT=4, set on agent 0 at cycle t -> reservation_valid[0]=1 for cycles t+1..t+4, then 0.
REQ-022 Simultaneous set+clear on agent 3, and set on agent 0 with an agent 1 store to the same granule -> both reservations valid next cycle.
REQ-023 Signed vs unsigned: MIN rs1=0xFFFFFFFF, rs2=1 -> rd=0xFFFFFFFF; MINU with the same operands -> rd=1.
REQ-024 Reset mid-RMW: rst low in the cycle after a grant -> rd_valid never asserts and rd=0.
